// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding and port ids.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GNT_I = 2'b01,
    S_GNT_D = 2'b11,
    S_RESP  = 2'b10
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector for the I/D ports.
// MEM_ARB_DPRIO_EN: port D always wins a tie; otherwise round-robin on last_gnt_i.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req_i_i,
  input  logic req_d_i,
  input  logic last_gnt_i,
  output logic gnt_vld_o,
  output logic gnt_id_o
);

  assign gnt_vld_o = req_i_i | req_d_i;

`ifdef MEM_ARB_DPRIO_EN
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt_i;
  assign gnt_id_o        = req_d_i ? PORT_D : PORT_I;
`else
  always_comb begin
    gnt_id_o = PORT_I;
    if (req_i_i && req_d_i) begin
      // The port that did not win last time takes the tie.
      gnt_id_o = (last_gnt_i == PORT_D) ? PORT_I : PORT_D;
    end else if (req_d_i) begin
      gnt_id_o = PORT_D;
    end
  end
`endif

endmodule

// File: rtl/mem_axi_arbiter.sv
// Shares one AXI translator between the instruction-fetch (I) and load/store (D) ports.
// Tie policy is selected inside mem_arb_pick by MEM_ARB_DPRIO_EN.
module mem_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              I_RDEN,
  input  logic [ADDR_W-1:0] I_RADDR,
  output logic              I_RVALID,
  output logic [DATA_W-1:0] I_RDATA,
  output logic              I_BUSY,
  input  logic              D_RDEN,
  input  logic [ADDR_W-1:0] D_RADDR,
  input  logic              D_WREN,
  input  logic [ADDR_W-1:0] D_WADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_RVALID,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              D_WDONE,
  output logic              D_BUSY,
  output logic              M_RDEN,
  output logic [ADDR_W-1:0] M_RIADDR,
  input  logic              M_RVALID,
  input  logic [DATA_W-1:0] M_RDATA,
  output logic              M_WREN,
  output logic [ADDR_W-1:0] M_WADDR,
  output logic [DATA_W-1:0] M_WDATA,
  input  logic              M_LOADING
);

  import mem_arb_pkg::*;

  arb_state_e        state_q, state_d;
  logic              last_gnt_q, gnt_port_q;
  logic              op_rd_q, op_wr_q;
  logic              rden_q, wren_q;
  logic              rd_done_q, wr_done_q;
  logic              first_q;
  logic [ADDR_W-1:0] raddr_q, waddr_q;
  logic [DATA_W-1:0] wdata_q, i_rdata_q, d_rdata_q;

  logic d_req, gnt_vld, gnt_id;
  logic in_gnt, rd_hit, wr_hit, rd_fin, wr_fin, resp_i, resp_d;

  assign d_req  = D_RDEN | D_WREN;
  assign in_gnt = (state_q == S_GNT_I) || (state_q == S_GNT_D);
  assign rd_hit = rden_q & M_RVALID;
  // The translator's LOADING lags our enable by one cycle, so a write cannot finish in the first grant cycle.
  assign wr_hit = wren_q & ~first_q & ~M_LOADING;
  assign rd_fin = ~op_rd_q | rd_done_q | rd_hit;
  assign wr_fin = ~op_wr_q | wr_done_q | wr_hit;
  assign resp_i = (state_q == S_RESP) && (gnt_port_q == PORT_I);
  assign resp_d = (state_q == S_RESP) && (gnt_port_q == PORT_D);

  mem_arb_pick u_pick (
    .req_i_i    (I_RDEN),
    .req_d_i    (d_req),
    .last_gnt_i (last_gnt_q),
    .gnt_vld_o  (gnt_vld),
    .gnt_id_o   (gnt_id)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:          if (gnt_vld) state_d = (gnt_id == PORT_D) ? S_GNT_D : S_GNT_I;
      S_GNT_I, S_GNT_D: if (rd_fin && wr_fin) state_d = S_RESP;
      S_RESP:          state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
  end

  always_comb begin
    I_RVALID = resp_i;
    D_RVALID = resp_d & op_rd_q;
    D_WDONE  = resp_d & op_wr_q;
    I_BUSY   = I_RDEN & ~resp_i;
    D_BUSY   = d_req & ~resp_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_gnt_q <= PORT_D;
      gnt_port_q <= PORT_I;
      op_rd_q    <= 1'b0;
      op_wr_q    <= 1'b0;
      rden_q     <= 1'b0;
      wren_q     <= 1'b0;
      rd_done_q  <= 1'b0;
      wr_done_q  <= 1'b0;
      first_q    <= 1'b0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else if (state_q == S_IDLE && gnt_vld) begin
      gnt_port_q <= gnt_id;
      first_q    <= 1'b1;
      rd_done_q  <= 1'b0;
      wr_done_q  <= 1'b0;
      if (gnt_id == PORT_I) begin
        op_rd_q <= 1'b1;
        op_wr_q <= 1'b0;
        rden_q  <= 1'b1;
        wren_q  <= 1'b0;
        raddr_q <= I_RADDR;
      end else begin
        op_rd_q <= D_RDEN;
        op_wr_q <= D_WREN;
        rden_q  <= D_RDEN;
        wren_q  <= D_WREN;
        raddr_q <= D_RADDR;
        waddr_q <= D_WADDR;
        wdata_q <= D_WDATA;
      end
    end else if (in_gnt) begin
      first_q <= 1'b0;
      if (rd_hit) begin
        rden_q    <= 1'b0;
        rd_done_q <= 1'b1;
        if (gnt_port_q == PORT_I) i_rdata_q <= M_RDATA;
        else                      d_rdata_q <= M_RDATA;
      end
      if (wr_hit) begin
        wren_q    <= 1'b0;
        wr_done_q <= 1'b1;
      end
    end else if (state_q == S_RESP) begin
      last_gnt_q <= gnt_port_q;
      rd_done_q  <= 1'b0;
      wr_done_q  <= 1'b0;
    end
  end

  assign M_RDEN   = rden_q;
  assign M_WREN   = wren_q;
  assign M_RIADDR = raddr_q;
  assign M_WADDR  = waddr_q;
  assign M_WDATA  = wdata_q;
  assign I_RDATA  = i_rdata_q;
  assign D_RDATA  = d_rdata_q;

endmodule
